// File: rtl/output_serializer_pkg.sv
// rtl/output_serializer_pkg.sv - shared types and sizing helpers for the output serializer
package output_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int CNT_W              = $clog2(DEFAULT_DATA_WIDTH);

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serializer_hold_reg.sv
// rtl/serializer_hold_reg.sv - one-entry holding register with load/drain controls
module serializer_hold_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  drain_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  output logic                  hold_valid_o,
  output logic [DATA_WIDTH-1:0] hold_data_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;

  always_comb begin
    valid_d = load_i | (valid_q & ~drain_i);
    data_d  = load_i ? load_data_i : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign hold_valid_o = valid_q;
  assign hold_data_o  = data_q;

endmodule

// File: rtl/output_serializer.sv
// rtl/output_serializer.sv - MSB-first parallel-to-serial transmitter with one-word holding register
module output_serializer
  import output_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  bit_en,
  output logic                  serial_out,
  output logic                  serial_valid,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic                  busy
);

  localparam int                   CW      = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0]        CNT_MAX = CW'(DATA_WIDTH - 1);

  ser_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q,   cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;

  logic                  hold_valid, hold_load, hold_drain;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  accept, frees;

  assign in_ready = ~hold_valid;
  assign accept   = in_valid & in_ready;
  assign frees    = (state_q == IDLE) || ((cnt_q == '0) && bit_en);

  serializer_hold_reg #(.DATA_WIDTH(DATA_WIDTH)) u_hold (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (hold_load),
    .drain_i      (hold_drain),
    .load_data_i  (in_data),
    .hold_valid_o (hold_valid),
    .hold_data_o  (hold_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // A held word always wins the freed shifter; an accept can only coexist with an empty hold.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    hold_load  = 1'b0;
    hold_drain = 1'b0;
    if (frees) begin
      if (hold_valid) begin
        state_d    = SHIFT;
        cnt_d      = CNT_MAX;
        shreg_d    = hold_data;
        hold_drain = 1'b1;
      end else if (accept) begin
        state_d = SHIFT;
        cnt_d   = CNT_MAX;
        shreg_d = in_data;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
        shreg_d = '0;
      end
    end else begin
      hold_load = accept;
      if (bit_en) begin
        shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - CW'(1);
      end
    end
  end

  assign serial_out = shreg_q[DATA_WIDTH-1];

  always_comb begin
    serial_valid = (state_q == SHIFT);
    frame_start  = serial_valid && (cnt_q == CNT_MAX);
    frame_end    = serial_valid && (cnt_q == '0);
    busy         = serial_valid | hold_valid;
  end

endmodule
